// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, branch resolution and the EX/MEM register.
// Define EX_MUL_EN to add the iterative 64-bit shift-add multiplier (alu_ctl 1100).
module ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] imm,
  input  logic [63:0] pc_plus4,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        branch,
  input  logic        alu_src,
  input  logic [3:0]  alu_ctl,
  input  logic        flush,
  output logic [63:0] alu_result_out,
  output logic [63:0] store_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        mem_to_reg_out,
  output logic        branch_taken,
  output logic [63:0] branch_target,
  output logic        stall
);
  logic [63:0] b, alu_y, result;
  assign b = alu_src ? imm : rs2_data;
  always_comb begin
    alu_y = '0;
    case (alu_ctl)
      4'b0000: alu_y = rs1_data & b;
      4'b0001: alu_y = rs1_data | b;
      4'b0010: alu_y = rs1_data + b;
      4'b0110: alu_y = rs1_data - b;
      4'b1000: alu_y = rs1_data ^ b;
      4'b0111: alu_y = {63'd0, $signed(rs1_data) < $signed(b)};
      4'b1001: alu_y = rs1_data << b[5:0];
      4'b1010: alu_y = rs1_data >> b[5:0];
      4'b1011: alu_y = $unsigned($signed(rs1_data) >>> b[5:0]);
      default: alu_y = '0;
    endcase
  end
`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [63:0] mcand, mplier, acc;
  logic [5:0]  count;
  logic        is_mul;
  assign is_mul = alu_ctl == 4'b1100;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = flush ? IDLE :
               state == IDLE ? (is_mul ? RUN : IDLE) :
               state == RUN ? (count == 6'd63 ? DONE : RUN) : IDLE;
    stall = (state == IDLE && is_mul && !flush) || state == RUN;
    result = state == DONE ? acc : alu_y;
  end
  // one shift-add step per RUN cycle; 64 steps leave the low product in acc
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      count <= '0;
    end else if (state == IDLE && is_mul && !flush) begin
      mcand <= rs1_data;
      mplier <= b;
      acc <= '0;
      count <= '0;
    end else if (state == RUN && !flush) begin
      acc <= acc + (mplier[0] ? mcand : 64'd0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      count <= count + 6'd1;
    end
`else
  assign stall = 1'b0;
  assign result = alu_y;
`endif
  assign branch_taken = branch && (rs1_data == rs2_data) && !flush && !stall;
  assign branch_target = pc_plus4 - 64'd4 + imm;
  always_ff @(posedge clock or posedge reset)
    if (reset)
      {alu_result_out, store_data_out, rd_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out} <= '0;
    else if (flush || stall)
      {alu_result_out, store_data_out, rd_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out} <= '0;
    else
      {alu_result_out, store_data_out, rd_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out} <=
        {result, rs2_data, rd, reg_write, mem_read, mem_write, mem_to_reg};
endmodule
